// File: rtl/bp_me_lce_latency_monitor.sv
// Multi-LCE coherence transaction monitor: per-LCE request latency tracking,
// log2 latency histogram, max latency, message counts and sticky flags.
module bp_me_lce_latency_monitor #(
    parameter int num_lce_p   = 2,
    parameter int cnt_width_p = 32,
    parameter int num_bins_p  = 8,
    parameter int timeout_p   = 1024,
    localparam int lce_w      = (num_lce_p > 1) ? $clog2(num_lce_p) : 1,
    localparam int bin_w      = $clog2(num_bins_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [num_lce_p-1:0]   req_v_i,
    input  logic [num_lce_p-1:0]   req_ready_and_i,
    input  logic [num_lce_p-1:0]   cmd_v_i,
    input  logic [num_lce_p-1:0]   cmd_ready_and_i,
    input  logic [num_lce_p-1:0]   complete_i,
    input  logic                   clear_i,
    input  logic [lce_w-1:0]       rd_lce_i,
    input  logic [bin_w-1:0]       rd_bin_i,
    output logic [cnt_width_p-1:0] hist_o,
    output logic [cnt_width_p-1:0] max_lat_o,
    output logic [cnt_width_p-1:0] req_cnt_o,
    output logic [cnt_width_p-1:0] cmd_cnt_o,
    output logic [num_lce_p-1:0]   pending_o,
    output logic [num_lce_p-1:0]   timeout_o,
    output logic [num_lce_p-1:0]   err_o
);

    typedef enum logic {IDLE, PEND} state_e;
    typedef logic [cnt_width_p-1:0] cnt_t;

    localparam cnt_t cnt_max_c = '1;
    localparam cnt_t timeout_c = cnt_width_p'(timeout_p);

    function automatic cnt_t sat_inc(input cnt_t x);
        return (x == cnt_max_c) ? x : x + cnt_width_p'(1);
    endfunction

    // Histogram bin is the index of the leading one, clamped to the last bin.
    function automatic logic [bin_w-1:0] bin_of(input cnt_t l);
        int msb;
        msb = 0;
        for (int b = 0; b < cnt_width_p; b++) begin
            if (l[b]) msb = b;
        end
        if (msb >= num_bins_p - 1) return bin_w'(num_bins_p - 1);
        return bin_w'(msb);
    endfunction

    state_e state_q [num_lce_p];
    state_e state_d [num_lce_p];
    cnt_t   lat_q   [num_lce_p];
    cnt_t   lat_d   [num_lce_p];
    cnt_t   lat_sat [num_lce_p];

    cnt_t   hist_q    [num_lce_p][num_bins_p];
    cnt_t   max_lat_q [num_lce_p];
    cnt_t   req_cnt_q [num_lce_p];
    cnt_t   cmd_cnt_q [num_lce_p];

    logic [num_lce_p-1:0] req_fire, cmd_fire;
    logic [num_lce_p-1:0] record, err_set, to_set;

    assign req_fire = req_v_i & req_ready_and_i;
    assign cmd_fire = cmd_v_i & cmd_ready_and_i;

    // NOTE: every signal written here gets a default before the case, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        record  = '0;
        err_set = '0;
        to_set  = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            state_d[i] = state_q[i];
            lat_d[i]   = lat_q[i];
            lat_sat[i] = sat_inc(lat_q[i]);
            case (state_q[i])
                IDLE: begin
                    err_set[i] = complete_i[i];
                    if (req_fire[i]) begin
                        state_d[i] = PEND;
                        lat_d[i]   = '0;
                    end
                end
                PEND: begin
                    lat_d[i]   = lat_sat[i];
                    to_set[i]  = (lat_sat[i] >= timeout_c);
                    record[i]  = complete_i[i];
                    err_set[i] = req_fire[i] & ~complete_i[i];
                    // A new request always restarts the count; only a bare completion leaves PEND.
                    if (req_fire[i]) lat_d[i] = '0;
                    else if (complete_i[i]) state_d[i] = IDLE;
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_lce_p; i++) begin
                state_q[i] <= IDLE;
                lat_q[i]   <= '0;
            end
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // NOTE: the stat arrays are flop-based and reset explicitly, since reads must return 0 straight out of reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_lce_p; i++) begin
                for (int b = 0; b < num_bins_p; b++) hist_q[i][b] <= '0;
                max_lat_q[i] <= '0;
                req_cnt_q[i] <= '0;
                cmd_cnt_q[i] <= '0;
            end
            timeout_o <= '0;
            err_o     <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < num_lce_p; i++) begin
                for (int b = 0; b < num_bins_p; b++) hist_q[i][b] <= '0;
                max_lat_q[i] <= '0;
                req_cnt_q[i] <= '0;
                cmd_cnt_q[i] <= '0;
            end
            timeout_o <= '0;
            err_o     <= '0;
        end else begin
            for (int i = 0; i < num_lce_p; i++) begin
                if (record[i]) begin
                    hist_q[i][bin_of(lat_sat[i])] <= sat_inc(hist_q[i][bin_of(lat_sat[i])]);
                    if (lat_sat[i] > max_lat_q[i]) max_lat_q[i] <= lat_sat[i];
                end
                if (req_fire[i]) req_cnt_q[i] <= sat_inc(req_cnt_q[i]);
                if (cmd_fire[i]) cmd_cnt_q[i] <= sat_inc(cmd_cnt_q[i]);
                if (to_set[i])   timeout_o[i] <= 1'b1;
                if (err_set[i])  err_o[i]     <= 1'b1;
            end
        end
    end

    always_comb begin
        pending_o = '0;
        for (int i = 0; i < num_lce_p; i++) pending_o[i] = (state_q[i] == PEND);
    end

    always_comb begin
        hist_o    = '0;
        max_lat_o = '0;
        req_cnt_o = '0;
        cmd_cnt_o = '0;
        if (int'(rd_lce_i) < num_lce_p) begin
            hist_o    = hist_q[rd_lce_i][rd_bin_i];
            max_lat_o = max_lat_q[rd_lce_i];
            req_cnt_o = req_cnt_q[rd_lce_i];
            cmd_cnt_o = cmd_cnt_q[rd_lce_i];
        end
    end

endmodule

// File: tb/tb_bp_me_lce_latency_monitor.sv
// Directed bench for bp_me_lce_latency_monitor: a reference model feeds a queue of
// expected stat reads; a narrow-counter instance shares the stimulus for saturation.
module tb_bp_me_lce_latency_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic [1:0] req_v, req_rdy, cmd_v, cmd_rdy, complete;
    logic       clear;
    logic       rd_lce;
    logic [2:0] rd_bin;

    logic [31:0] hist, max_lat, req_cnt, cmd_cnt;
    logic [1:0]  pending, timeout, err;
    logic [3:0]  w_hist, w_max, w_req, w_cmd;
    logic [1:0]  w_pending, w_timeout, w_err;

    bp_me_lce_latency_monitor #(
        .num_lce_p(2), .cnt_width_p(32), .num_bins_p(8), .timeout_p(16)
    ) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(req_v), .req_ready_and_i(req_rdy),
        .cmd_v_i(cmd_v), .cmd_ready_and_i(cmd_rdy),
        .complete_i(complete), .clear_i(clear),
        .rd_lce_i(rd_lce), .rd_bin_i(rd_bin),
        .hist_o(hist), .max_lat_o(max_lat), .req_cnt_o(req_cnt), .cmd_cnt_o(cmd_cnt),
        .pending_o(pending), .timeout_o(timeout), .err_o(err)
    );

    bp_me_lce_latency_monitor #(
        .num_lce_p(2), .cnt_width_p(4), .num_bins_p(8), .timeout_p(15)
    ) dut_w (
        .clk_i(clk), .reset_n_i(reset_n),
        .req_v_i(req_v), .req_ready_and_i(req_rdy),
        .cmd_v_i(cmd_v), .cmd_ready_and_i(cmd_rdy),
        .complete_i(complete), .clear_i(clear),
        .rd_lce_i(rd_lce), .rd_bin_i(rd_bin),
        .hist_o(w_hist), .max_lat_o(w_max), .req_cnt_o(w_req), .cmd_cnt_o(w_cmd),
        .pending_o(w_pending), .timeout_o(w_timeout), .err_o(w_err)
    );

    int checks   = 0;
    int failures = 0;

    typedef enum {K_HIST, K_MAX, K_REQ, K_CMD, W_HIST, W_MAX} kind_e;
    typedef struct {
        string       tag;
        kind_e       kind;
        int          lce;
        int          bin;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    int exp_hist [2][8];
    int exp_max  [2];
    int exp_req  [2];
    int exp_cmd  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tb_bin(input int l);
        int v, b;
        v = l;
        b = 0;
        while (v > 1) begin
            v = v >> 1;
            b++;
        end
        return (b > 7) ? 7 : b;
    endfunction

    task automatic model_zero();
        for (int i = 0; i < 2; i++) begin
            for (int b = 0; b < 8; b++) exp_hist[i][b] = 0;
            exp_max[i] = 0;
            exp_req[i] = 0;
            exp_cmd[i] = 0;
        end
    endtask

    task automatic model_record(input int lce, input int l);
        exp_hist[lce][tb_bin(l)]++;
        if (l > exp_max[lce]) exp_max[lce] = l;
    endtask

    task automatic push(input string tag, input kind_e kind, input int lce, input int bin, input int exp);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.lce  = lce;
        e.bin  = bin;
        e.exp  = 32'(exp);
        sb.push_back(e);
    endtask

    task automatic expect_stats(input string tag, input int lce);
        for (int b = 0; b < 8; b++)
            push($sformatf("%s_hist%0d_b%0d", tag, lce, b), K_HIST, lce, b, exp_hist[lce][b]);
        push($sformatf("%s_max%0d", tag, lce), K_MAX, lce, 0, exp_max[lce]);
        push($sformatf("%s_req%0d", tag, lce), K_REQ, lce, 0, exp_req[lce]);
        push($sformatf("%s_cmd%0d", tag, lce), K_CMD, lce, 0, exp_cmd[lce]);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e      = sb.pop_front();
            rd_lce = 1'(e.lce);
            rd_bin = 3'(e.bin);
            #1;
            case (e.kind)
                K_HIST:  obs = hist;
                K_MAX:   obs = max_lat;
                K_REQ:   obs = req_cnt;
                K_CMD:   obs = cmd_cnt;
                W_HIST:  obs = 32'(w_hist);
                default: obs = 32'(w_max);
            endcase
            check(e.tag, obs, e.exp);
        end
    endtask

    task automatic txn(input int lce, input int l, output int pend_cycles);
        req_v[lce] = 1'b1;
        step();
        req_v[lce] = 1'b0;
        pend_cycles = 0;
        if (pending[lce]) pend_cycles++;
        repeat (l - 1) begin
            step();
            if (pending[lce]) pend_cycles++;
        end
        complete[lce] = 1'b1;
        step();
        complete[lce] = 1'b0;
        exp_req[lce]++;
        model_record(lce, l);
    endtask

    initial begin
        int pc;
        reset_n  = 1'b0;
        req_v    = '0;
        req_rdy  = 2'b11;
        cmd_v    = '0;
        cmd_rdy  = 2'b11;
        complete = '0;
        clear    = 1'b0;
        rd_lce   = 1'b0;
        rd_bin   = '0;
        model_zero();
        repeat (2) step();

        // Reset state
        check("rst_pending", 32'(pending), 0);
        check("rst_timeout", 32'(timeout), 0);
        check("rst_err", 32'(err), 0);
        expect_stats("rst", 0);
        expect_stats("rst", 1);
        drain();
        reset_n = 1'b1;
        step();

        // Handshake gating: valid without ready never fires
        req_v   = 2'b01;
        req_rdy = 2'b00;
        step();
        req_v   = '0;
        req_rdy = 2'b11;
        check("gate_pending", 32'(pending), 0);
        cmd_v = 2'b01;
        step();
        cmd_rdy = 2'b10;
        step();
        cmd_rdy = 2'b11;
        step();
        cmd_v = '0;
        exp_cmd[0] = 2;

        // L=5 on LCE0
        txn(0, 5, pc);
        check("t1_pend_cycles", 32'(pc), 5);
        check("t1_pend_low", 32'(pending[0]), 0);
        expect_stats("t1", 0);
        drain();

        // Latencies 1, 3, 200 on LCE1
        txn(1, 1, pc);
        txn(1, 3, pc);
        txn(1, 200, pc);
        expect_stats("t2", 1);
        expect_stats("t2", 0);
        drain();
        check("t2_timeout1", 32'(timeout[1]), 1);
        check("t2_timeout0", 32'(timeout[0]), 0);
        check("t2_err", 32'(err), 0);

        // Completion with nothing outstanding
        complete = 2'b01;
        step();
        complete = '0;
        check("t4_err0", 32'(err[0]), 1);
        check("t4_err1", 32'(err[1]), 0);
        check("t4_pending", 32'(pending), 0);
        expect_stats("t4", 0);
        drain();
        clear = 1'b1;
        step();
        clear = 1'b0;
        model_zero();
        check("t4_clr_err", 32'(err), 0);
        check("t4_clr_timeout", 32'(timeout), 0);
        expect_stats("t4clr", 0);
        expect_stats("t4clr", 1);
        drain();

        // Clear beats a same-cycle recording
        req_v[1] = 1'b1;
        step();
        req_v[1] = 1'b0;
        step();
        complete[1] = 1'b1;
        clear       = 1'b1;
        step();
        complete[1] = 1'b0;
        clear       = 1'b0;
        check("cw_pending", 32'(pending[1]), 0);
        expect_stats("cw", 1);
        drain();

        // Clear leaves an outstanding request tracked
        req_v[1] = 1'b1;
        step();
        req_v[1] = 1'b0;
        clear    = 1'b1;
        step();
        clear = 1'b0;
        check("cf_pending", 32'(pending[1]), 1);
        step();
        complete[1] = 1'b1;
        step();
        complete[1] = 1'b0;
        model_record(1, 3);
        expect_stats("cf", 1);
        drain();

        // Timeout at L=16, held to L=20; narrow instance saturates at 15
        req_v[0] = 1'b1;
        step();
        req_v[0] = 1'b0;
        repeat (15) step();
        check("t3_timeout_pre", 32'(timeout[0]), 0);
        check("t3_w_timeout", 32'(w_timeout[0]), 1);
        step();
        check("t3_timeout_set", 32'(timeout[0]), 1);
        repeat (3) step();
        complete[0] = 1'b1;
        step();
        complete[0] = 1'b0;
        exp_req[0]++;
        model_record(0, 20);
        check("t3_timeout_sticky", 32'(timeout[0]), 1);
        expect_stats("t3", 0);
        push("t3_w_hist_b3", W_HIST, 0, 3, 1);
        push("t3_w_hist_b4", W_HIST, 0, 4, 0);
        push("t3_w_max", W_MAX, 0, 0, 15);
        drain();

        // Completion and new request in the same cycle
        req_v[1] = 1'b1;
        step();
        req_v[1] = 1'b0;
        repeat (3) step();
        complete[1] = 1'b1;
        req_v[1]    = 1'b1;
        step();
        complete[1] = 1'b0;
        req_v[1]    = 1'b0;
        check("t5_pending", 32'(pending[1]), 1);
        check("t5_err", 32'(err[1]), 0);
        repeat (2) step();
        complete[1] = 1'b1;
        step();
        complete[1] = 1'b0;
        exp_req[1] += 2;
        model_record(1, 4);
        model_record(1, 3);
        check("t5_pending_low", 32'(pending[1]), 0);
        expect_stats("t5", 1);
        drain();

        // Re-request while pending drops the old request
        req_v[0] = 1'b1;
        step();
        req_v[0] = 1'b0;
        step();
        req_v[0] = 1'b1;
        step();
        req_v[0] = 1'b0;
        check("t6_err", 32'(err[0]), 1);
        check("t6_pending", 32'(pending[0]), 1);
        step();
        complete[0] = 1'b1;
        step();
        complete[0] = 1'b0;
        exp_req[0] += 2;
        model_record(0, 2);
        expect_stats("t6", 0);
        drain();

        // Reset mid-request
        req_v[0] = 1'b1;
        step();
        req_v[0] = 1'b0;
        repeat (3) step();
        reset_n = 1'b0;
        #1;
        model_zero();
        check("rm_pending", 32'(pending), 0);
        check("rm_timeout", 32'(timeout), 0);
        check("rm_err", 32'(err), 0);
        check("rm_w_pending", 32'(w_pending), 0);
        check("rm_w_err", 32'(w_err), 0);
        expect_stats("rm", 0);
        expect_stats("rm", 1);
        push("rm_w_hist_b3", W_HIST, 0, 3, 0);
        push("rm_w_max", W_MAX, 0, 0, 0);
        drain();
        reset_n = 1'b1;
        step();
        complete[0] = 1'b1;
        step();
        complete[0] = 1'b0;
        check("rm_late_err", 32'(err[0]), 1);
        check("rm_late_pending", 32'(pending[0]), 0);
        expect_stats("rm_late", 0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bp_me_lce_latency_monitor.md
Name: bp_me_lce_latency_monitor

Overview:
- Parametrised multi-LCE transaction monitor for the LCE-CCE interface, instantiated beside the caches in test harnesses.
- Tracks one outstanding coherence request per LCE and measures its latency from request handshake to cache-request completion.
- Bins each latency into a per-LCE log2 histogram, records per-LCE maximum latency and message counts, and raises sticky timeout and protocol-error flags.
- Generalises single-LCE latency printing to N channels with stats readable through a read port.

Parameters:
- num_lce_p, 2, number of monitored LCEs.
- cnt_width_p, 32, width of every latency, histogram and message counter.
- num_bins_p, 8, histogram bins per LCE; power of two, >=2.
- timeout_p, 1024, latency in cycles at which timeout is flagged; 1 <= timeout_p < 2^cnt_width_p.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous active-low reset.
- req_v_i  in  num_lce_p  LCE request valid, per LCE.
- req_ready_and_i  in  num_lce_p  LCE request ready, per LCE.
- cmd_v_i  in  num_lce_p  CCE-to-LCE command valid.
- cmd_ready_and_i  in  num_lce_p  CCE-to-LCE command ready.
- complete_i  in  num_lce_p  cache request complete pulse.
- clear_i  in  1  synchronous clear of stats and sticky flags.
- rd_lce_i  in  clog2(num_lce_p)  stat read LCE select.
- rd_bin_i  in  clog2(num_bins_p)  histogram bin select.
- hist_o  out  cnt_width_p  hist[rd_lce_i][rd_bin_i].
- max_lat_o  out  cnt_width_p  max latency of rd_lce_i.
- req_cnt_o  out  cnt_width_p  accepted requests of rd_lce_i.
- cmd_cnt_o  out  cnt_width_p  accepted commands of rd_lce_i.
- pending_o  out  num_lce_p  request outstanding, per LCE.
- timeout_o  out  num_lce_p  sticky timeout, per LCE.
- err_o  out  num_lce_p  sticky protocol error, per LCE.

Behaviour:
- Async reset (reset_n_i=0): all counters, histograms, max_lat and flags = 0; all FSMs IDLE. Outputs read 0.
- req fire[i] = req_v_i[i] & req_ready_and_i[i]. cmd fire is defined the same way.
- Per-LCE FSM:
  - IDLE -> PEND on req fire; latency counter lat[i] loads 0.
  - PEND: lat[i] increments each cycle, saturating at 2^cnt_width_p-1.
  - PEND -> IDLE on complete_i[i]. The recorded latency is L = lat[i]+1, saturating. Request fires at cycle t and complete at t+L gives latency L.
- Recording:
  - bin = min(floor(log2(L)), num_bins_p-1); hist[i][bin] += 1, saturating.
  - max_lat[i] = max(max_lat[i], L).
- pending_o[i] = 1 in PEND.
- Timeout: in PEND, when L reaches timeout_p, timeout_o[i] sets (sticky). Tracking continues; the eventual completion is still recorded.
- Errors, all setting err_o[i] sticky:
  - complete_i[i] in IDLE: no recording, state unchanged except as set by a same-cycle req fire.
  - req fire in PEND without same-cycle complete: the old request is dropped unrecorded, lat restarts at 0, state stays PEND.
- PEND with complete and req fire in the same cycle: legal. Record L, stay PEND, lat loads 0.
- req_cnt[i] and cmd_cnt[i] increment on their fire and saturate.
- clear_i:
  - Zeroes hist, max_lat, req_cnt, cmd_cnt, timeout_o, err_o for all LCEs.
  - FSM state and lat are unaffected.
  - Clear wins over same-cycle recording, counting and flag setting.
- Read outputs are combinational from registers, with zero-cycle latency; out-of-range rd_lce_i reads 0.
- Reset mid-request: the request is forgotten; the next completion raises err_o.

Test Plan:
- LCE0 req fire at t, complete at t+5 -> hist[0][2]=1, max_lat=5, req_cnt=1, pending_o[0] high for 5 cycles then low.
- Latencies 1, 3, 200 on LCE1 (num_bins_p=8) -> hist bins 0, 1, 7 each =1; max_lat=200; LCE0 stats unchanged.
- timeout_p=16; request held 20 cycles then completed -> timeout_o set at L=16 and stays high; hist[.][4]=1.
- complete_i[0] with no request -> err_o[0]=1, all hist 0. Then clear_i -> err_o=0 and counters 0.
- PEND with complete and req fire same cycle -> recorded once, pending_o stays 1, next completion 3 cycles later records L=3.
- cnt_width_p=4; request held 20 cycles -> recorded L=15, bin 3. Assert reset_n_i mid-request -> all outputs 0 immediately.
